// File: rtl/timer_scheduler_pkg.sv
// Shared types for the alarm scheduler: FSM states, per-channel record, index width helper.
package timer_scheduler_pkg;
    localparam int TW_DEF = 32;

    typedef enum logic {INIT, RUN} fsm_t;

    typedef struct packed {
        logic              active;
        logic              periodic;
        logic [TW_DEF-1:0] deadline;
        logic [TW_DEF-1:0] period;
    } ch_rec_t;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/timer_sched_cmp.sv
// Wrap-safe expiry test for one channel record and the drift-free reload deadline.
module timer_sched_cmp #(
    parameter int TW = 32
) (
    input  logic [TW-1:0] time_us,
    input  logic [TW-1:0] deadline,
    input  logic [TW-1:0] period,
    input  logic          active,
    output logic          expired,
    output logic [TW-1:0] next_deadline
);
    logic [TW-1:0] diff;

    // Non-negative signed difference means the deadline has been reached.
    assign diff          = time_us - deadline;
    assign expired       = active && !diff[TW-1];
    assign next_deadline = deadline + period;
endmodule

// File: rtl/timer_scheduler.sv
// Multi-channel alarm scheduler: one shared comparator scans channel records round-robin.
module timer_scheduler
    import timer_scheduler_pkg::*;
#(
    parameter int N_CH = 8,
    parameter int TW   = TW_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [TW-1:0]          time_us,
    input  logic                   arm_valid,
    output logic                   arm_ready,
    input  logic [ch_w(N_CH)-1:0]  arm_ch,
    input  logic                   arm_cancel,
    input  logic                   arm_periodic,
    input  logic [TW-1:0]          arm_delay,
    input  logic [N_CH-1:0]        ack,
    output logic [N_CH-1:0]        pending,
    output logic [N_CH-1:0]        overrun,
    output logic [N_CH-1:0]        active,
    output logic                   irq
);
    localparam int CH_W = ch_w(N_CH);

    fsm_t            state_q, state_d;
    logic [CH_W-1:0] idx_q, idx_d;
    logic [N_CH-1:0] pending_q, pending_d;
    logic [N_CH-1:0] overrun_q, overrun_d;
    logic            irq_q, irq_d;
    ch_rec_t         rec_q [N_CH];
    ch_rec_t         rec_d [N_CH];

    ch_rec_t         cur;
    logic            expired;
    logic [TW-1:0]   next_deadline;
    logic            arm_fire;

    assign cur       = rec_q[idx_q];
    assign arm_ready = (state_q == RUN);
    assign arm_fire  = arm_valid && arm_ready;

    timer_sched_cmp #(.TW(TW)) u_cmp (
        .time_us       (time_us),
        .deadline      (cur.deadline),
        .period        (cur.period),
        .active        (cur.active && (state_q == RUN)),
        .expired       (expired),
        .next_deadline (next_deadline)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q + 1'b1;
        pending_d = pending_q & ~ack;
        overrun_d = overrun_q & ~ack;
        irq_d     = |pending_q;
        rec_d     = rec_q;
        if (state_q == INIT) begin
            rec_d[idx_q] = '0;
            if (idx_q == CH_W'(N_CH - 1)) state_d = RUN;
        end else begin
            if (expired) begin
                pending_d[idx_q] = 1'b1;
                if (pending_q[idx_q] && !ack[idx_q]) overrun_d[idx_q] = 1'b1;
            end
            // Single write port: a request owns it, otherwise the scan writeback.
            if (arm_fire) begin
                if (arm_cancel) begin
                    rec_d[arm_ch].active = 1'b0;
                end else begin
                    rec_d[arm_ch].active   = 1'b1;
                    rec_d[arm_ch].periodic = arm_periodic && (arm_delay != '0);
                    rec_d[arm_ch].deadline = time_us + arm_delay;
                    rec_d[arm_ch].period   = arm_delay;
                end
            end else if (expired) begin
                if (cur.periodic) rec_d[idx_q].deadline = next_deadline;
                else              rec_d[idx_q].active   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= INIT;
            idx_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) rec_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
            for (int i = 0; i < N_CH; i++) rec_q[i] <= rec_d[i];
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_act
        assign active[g] = rec_q[g].active;
    end

    assign pending = pending_q;
    assign overrun = overrun_q;
    assign irq     = irq_q;
endmodule

// File: tb/tb_timer_scheduler.sv
// Scenario bench for timer_scheduler; expected flag vectors flow through a scoreboard queue.
module tb_timer_scheduler;
    localparam int N_CH = 8;
    localparam int TW   = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [TW-1:0] time_us = '0;
    logic          arm_valid = 1'b0;
    logic          arm_ready;
    logic [2:0]    arm_ch = '0;
    logic          arm_cancel = 1'b0;
    logic          arm_periodic = 1'b0;
    logic [TW-1:0] arm_delay = '0;
    logic [7:0]    ack = '0;
    logic [7:0]    pending, overrun, active;
    logic          irq;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] pend;
        logic [7:0] ovr;
        logic [7:0] act;
    } exp_t;
    exp_t exp_q[$];

    timer_scheduler #(.N_CH(N_CH), .TW(TW)) dut (
        .clk(clk), .reset(reset), .time_us(time_us),
        .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_ch(arm_ch),
        .arm_cancel(arm_cancel), .arm_periodic(arm_periodic), .arm_delay(arm_delay),
        .ack(ack), .pending(pending), .overrun(overrun), .active(active), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm_req(input logic [2:0] ch, input logic cancel, input logic periodic,
                           input logic [TW-1:0] delay);
        @(posedge clk); #1;
        arm_valid = 1'b1; arm_ch = ch; arm_cancel = cancel;
        arm_periodic = periodic; arm_delay = delay;
        @(posedge clk); #1;
        arm_valid = 1'b0; arm_cancel = 1'b0; arm_periodic = 1'b0;
    endtask

    task automatic ack_req(input logic [7:0] mask);
        @(posedge clk); #1;
        ack = mask;
        @(posedge clk); #1;
        ack = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (pending !== 0 || overrun !== 0 || active !== 0 || irq !== 0 || arm_ready !== 0) begin
            failures++;
            $display("FAIL reset_hold: pend=%h ovr=%h act=%h irq=%b rdy=%b, want all 0",
                     pending, overrun, active, irq, arm_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (arm_ready !== (k == 8) || pending !== 0 || overrun !== 0 || active !== 0 || irq !== 0) begin
                failures++;
                $display("FAIL init_clk%0d: rdy=%b pend=%h act=%h irq=%b, want rdy=%b others 0",
                         k, arm_ready, pending, active, irq, (k == 8));
            end
        end
    endtask

    task automatic test_oneshot();
        exp_t e;
        int n;
        time_us = 1000;
        arm_req(3, 0, 0, 5);
        time_us = 1004;
        hold(10);
        exp_q.push_back('{pend: 8'h00, ovr: 8'h00, act: 8'h08});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL oneshot_early: pend=%h ovr=%h act=%h, want %h %h %h",
                     pending, overrun, active, e.pend, e.ovr, e.act);
        end
        time_us = 1005;
        exp_q.push_back('{pend: 8'h08, ovr: 8'h00, act: 8'h00});
        n = 0;
        while (pending === 8'h00 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        e = exp_q.pop_front(); checks++;
        if (n > 8 || pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL oneshot_expire: clks=%0d pend=%h ovr=%h act=%h, want <=8 %h %h %h",
                     n, pending, overrun, active, e.pend, e.ovr, e.act);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq: irq=%b, want 1", irq);
        end
        ack_req(8'h08);
        checks++;
        if (pending !== 8'h00) begin
            failures++;
            $display("FAIL oneshot_ack: pend=%h, want 00", pending);
        end
        @(posedge clk); #1;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_clr: irq=%b, want 0", irq);
        end
    endtask

    task automatic test_periodic();
        exp_t e;
        int dl;
        logic pend, ovr;
        dl = 2; pend = 0; ovr = 0;
        time_us = 0;
        arm_req(0, 0, 1, 2);
        for (int t = 1; t <= 6; t++) begin
            time_us = t;
            hold(10);
            if (t >= dl) begin
                if (pend) ovr = 1;
                pend = 1;
                dl += 2;
            end
            exp_q.push_back('{pend: {7'b0, pend}, ovr: {7'b0, ovr}, act: 8'h01});
            e = exp_q.pop_front(); checks++;
            if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
                failures++;
                $display("FAIL periodic_t%0d: pend=%h ovr=%h act=%h, want %h %h %h",
                         t, pending, overrun, active, e.pend, e.ovr, e.act);
            end
            if (t == 4) begin
                ack_req(8'h01);
                pend = 0; ovr = 0;
                exp_q.push_back('{pend: 8'h00, ovr: 8'h00, act: 8'h01});
                e = exp_q.pop_front(); checks++;
                if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
                    failures++;
                    $display("FAIL periodic_ack: pend=%h ovr=%h act=%h, want %h %h %h",
                             pending, overrun, active, e.pend, e.ovr, e.act);
                end
            end
        end
    endtask

    task automatic test_cancel();
        exp_t e;
        arm_req(7, 1, 0, 0);
        exp_q.push_back('{pend: 8'h01, ovr: 8'h00, act: 8'h01});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL cancel_idle: pend=%h ovr=%h act=%h, want %h %h %h",
                     pending, overrun, active, e.pend, e.ovr, e.act);
        end
        arm_req(0, 1, 0, 0);
        exp_q.push_back('{pend: 8'h01, ovr: 8'h00, act: 8'h00});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL cancel_active: pend=%h ovr=%h act=%h, want %h %h %h",
                     pending, overrun, active, e.pend, e.ovr, e.act);
        end
        ack_req(8'hFF);
        hold(2);
    endtask

    task automatic test_wrap();
        exp_t e;
        logic [TW-1:0] tv [4];
        tv[0] = 32'hFFFF_FFFF; tv[1] = 32'h0; tv[2] = 32'h1; tv[3] = 32'h2;
        time_us = 32'hFFFF_FFFE;
        arm_req(5, 0, 0, 4);
        for (int k = 0; k < 4; k++) begin
            time_us = tv[k];
            hold(10);
            exp_q.push_back('{pend: (k == 3) ? 8'h20 : 8'h00, ovr: 8'h00,
                              act: (k == 3) ? 8'h00 : 8'h20});
            e = exp_q.pop_front(); checks++;
            if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
                failures++;
                $display("FAIL wrap_%h: pend=%h ovr=%h act=%h, want %h %h %h",
                         tv[k], pending, overrun, active, e.pend, e.ovr, e.act);
            end
        end
        ack_req(8'h20);
    endtask

    task automatic test_collision();
        exp_t e;
        int n;
        time_us = 5000;
        arm_req(2, 0, 1, 1);
        time_us = 5001;
        n = 0;
        while (pending[2] !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (pending[2] !== 1'b1) begin
            failures++;
            $display("FAIL coll_first: pend=%h after %0d clks, want bit2 set", pending, n);
            return;
        end
        // ch2 is next visited 8 clks after this one, with deadline 5002 due.
        time_us = 5002;
        repeat (7) @(posedge clk);
        #1;
        arm_valid = 1'b1; arm_ch = 2; arm_cancel = 1'b0; arm_periodic = 1'b0; arm_delay = 100;
        ack = 8'h04;
        @(posedge clk); #1;
        arm_valid = 1'b0; ack = '0;
        exp_q.push_back('{pend: 8'h04, ovr: 8'h00, act: 8'h04});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL coll_same_clk: pend=%h ovr=%h act=%h, want %h %h %h",
                     pending, overrun, active, e.pend, e.ovr, e.act);
        end
        ack_req(8'h04);
        time_us = 5101;
        hold(10);
        exp_q.push_back('{pend: 8'h00, ovr: 8'h00, act: 8'h04});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL coll_rearm_early: pend=%h ovr=%h act=%h, want %h %h %h",
                     pending, overrun, active, e.pend, e.ovr, e.act);
        end
        time_us = 5102;
        hold(10);
        exp_q.push_back('{pend: 8'h04, ovr: 8'h00, act: 8'h00});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act) begin
            failures++;
            $display("FAIL coll_rearm_due: pend=%h ovr=%h act=%h, want %h %h %h",
                     pending, overrun, active, e.pend, e.ovr, e.act);
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        time_us = 6000;
        arm_req(0, 0, 0, 50);
        arm_req(1, 0, 1, 50);
        arm_req(4, 0, 0, 50);
        arm_req(6, 0, 1, 50);
        checks++;
        if (active !== 8'h53 || irq !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: act=%h irq=%b, want 53 1", active, irq);
        end
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        checks++;
        if (pending !== 0 || overrun !== 0 || active !== 0 || irq !== 0 || arm_ready !== 0) begin
            failures++;
            $display("FAIL midrst_async: pend=%h ovr=%h act=%h irq=%b rdy=%b, want all 0",
                     pending, overrun, active, irq, arm_ready);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (arm_ready !== (k == 8) || pending !== 0 || active !== 0 || irq !== 0) begin
                failures++;
                $display("FAIL midrst_init%0d: rdy=%b pend=%h act=%h irq=%b, want rdy=%b others 0",
                         k, arm_ready, pending, active, irq, (k == 8));
            end
        end
        time_us = 6100;
        hold(20);
        exp_q.push_back('{pend: 8'h00, ovr: 8'h00, act: 8'h00});
        e = exp_q.pop_front(); checks++;
        if (pending !== e.pend || overrun !== e.ovr || active !== e.act || irq !== 1'b0) begin
            failures++;
            $display("FAIL midrst_stale: pend=%h ovr=%h act=%h irq=%b, want %h %h %h 0",
                     pending, overrun, active, irq, e.pend, e.ovr, e.act);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_cancel();
        test_wrap();
        test_collision();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
